// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-count link (generator and detector).
// State encoding is common to both ends so traces read the same.
package pulse_pkg;

  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HIGH = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter timing the HIGH and GAP phases.
// tc flags the last cycle of a phase (count value 1).
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Burst generator: emits 'count' pulses of HIGH_CYCLES width separated by GAP_CYCLES low.
// Moore outputs, all registered; start/count only sampled in IDLE.
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HIGH_CYCLES = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             outsig,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_sent
);

  localparam int PH_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] next_sent;
  logic             ph_load;
  logic [PH_W-1:0]  ph_val;
  logic             ph_tc;

  assign next_sent = pulses_sent + CNT_W'(1);

  always_comb begin
    ph_load = 1'b0;
    ph_val  = PH_W'(HIGH_CYCLES);
    case (state)
      S_IDLE: ph_load = start && (count != '0);
      S_HIGH: begin
        ph_load = ph_tc && (next_sent != target);
        ph_val  = PH_W'(GAP_CYCLES);
      end
      S_GAP:  ph_load = ph_tc;
      default: ph_load = 1'b0;
    endcase
  end

  phase_counter #(.W(PH_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .tc       (ph_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      target      <= '0;
      pulses_sent <= '0;
      outsig      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            target      <= count;
            pulses_sent <= '0;
            if (count != '0) begin
              state  <= S_HIGH;
              outsig <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (ph_tc) begin
            pulses_sent <= next_sent;
            outsig      <= 1'b0;
            // Full-width compare: target max is all-ones, so the counter never wraps.
            if (next_sent == target) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (ph_tc) begin
            state  <= S_HIGH;
            outsig <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen against a cycle-offset reference model.
// Checks directed bursts, boundary counts, async reset and back-to-back operation.
module tb_pulse_train_gen;

  localparam int CNT_W = 4;
  localparam int H     = 1;
  localparam int G     = 2;
  localparam int VW    = CNT_W + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] count;
  logic             outsig;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_sent;

  int checks = 0;
  int errors = 0;

  pulse_train_gen #(
    .CNT_W       (CNT_W),
    .HIGH_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .outsig      (outsig),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  always #5 clk = ~clk;

  // Expected {outsig, busy, done, pulses_sent} t cycles after the accepting edge.
  function automatic logic [VW-1:0] model(input int n, input int t);
    int   len;
    int   per;
    int   ps;
    logic o;
    len = (n == 0) ? 0 : n * H + (n - 1) * G;
    per = H + G;
    if (t >= 1 && t <= len) begin
      o  = (((t - 1) % per) < H);
      ps = (t >= H + 1) ? ((t - H - 1) / per + 1) : 0;
      return {o, 1'b1, 1'b0, CNT_W'(ps)};
    end else if (t == len + 1) begin
      return {1'b0, 1'b0, 1'b1, CNT_W'(n)};
    end
    return {1'b0, 1'b0, 1'b0, CNT_W'(n)};
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call at #1 after a posedge while the DUT is idle; the next edge accepts.
  task automatic run_burst(input int n, input bit hold, input bit disturb);
    int   len;
    int   rises;
    logic prev;
    len   = (n == 0) ? 0 : n * H + (n - 1) * G;
    rises = 0;
    prev  = 1'b0;
    start = 1'b1;
    count = CNT_W'(n);
    for (int t = 1; t <= len + 2; t++) begin
      @(posedge clk); #1;
      chk($sformatf("burst n=%0d t=%0d", n, t), {outsig, busy, done, pulses_sent}, model(n, t));
      if (outsig && !prev) rises++;
      prev = outsig;
      if (!hold) begin
        if (disturb && t < len) begin
          start = 1'($urandom_range(0, 1));
          count = CNT_W'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    chk($sformatf("edges n=%0d", n), VW'(rises), VW'(n));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    count = '0;
    #1 reset = 1'b0;
    #1 chk("reset_state", {outsig, busy, done, pulses_sent}, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_after_reset", {outsig, busy, done, pulses_sent}, '0);
    end

    run_burst(3, 1'b0, 1'b0);
    run_burst(0, 1'b0, 1'b0);
    run_burst(15, 1'b0, 1'b0);
    run_burst(3, 1'b0, 1'b1);

    // pulses_sent holds while idle even as count wiggles
    repeat (3) begin
      count = CNT_W'($urandom);
      @(posedge clk); #1;
      chk("hold_after_done", {outsig, busy, done, pulses_sent}, model(3, 100));
    end

    repeat (6) run_burst(int'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));

    repeat (3) run_burst(2, 1'b1, 1'b0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("after_hold", {outsig, busy, done, pulses_sent}, model(2, 100));

    // Async reset in the middle of pulse 2's HIGH phase
    start = 1'b1;
    count = CNT_W'(3);
    for (int t = 1; t <= 4; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_high", {outsig, busy, done, pulses_sent}, model(3, 4));
    #2 reset = 1'b0;
    #1 chk("async_reset", {outsig, busy, done, pulses_sent}, '0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("no_resume", {outsig, busy, done, pulses_sent}, '0);
    end

    run_burst(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Transmit side of the pulse-count link. On a start request it drives a programmable number of clean pulses on outsig for a downstream pulse detector to count.
- Pulse width and spacing are fixed by parameters. A start/busy/done handshake lets the lab top level or a controller FSM sequence bursts.
- Sits between the control logic (switches/keys or a sequencer) and the detector's insig input.

Parameters:
- CNT_W, 4, width of the count request and the pulses_sent counter. Max burst is 2^CNT_W-1.
- HIGH_CYCLES, 1, clock cycles outsig stays high per pulse. Must be >=1.
- GAP_CYCLES, 2, clock cycles outsig stays low between consecutive pulses. Must be >=1 so every pulse has a visible rising edge.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low. 0 clears all state immediately, independent of clk.
- start  input  1  burst request, sampled on rising clk edge in IDLE only.
- count  input  CNT_W  number of pulses to send, latched when start is accepted.
- outsig  output  1  pulse train to the detector (registered).
- busy  output  1  high while a burst is in progress (HIGH or GAP state).
- done  output  1  one-cycle completion strobe.
- pulses_sent  output  CNT_W  pulses completed in the current/last burst.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; outsig=0, busy=0, done=0, pulses_sent=0.
  - Internal target and phase counters are cleared.
  - Reset mid-burst aborts the burst. No pulse is resumed after release.
- All outputs are registered, Moore-style. No combinational path from start/count to outputs.
- States: IDLE, HIGH, GAP, DONE (2-bit encoding).
- IDLE, start=1 and count!=0:
  - Latch count into target, clear pulses_sent, load phase counter with HIGH_CYCLES.
  - Go to HIGH. outsig=1 and busy=1 from the next cycle (latency 1).
- IDLE, start=1 and count==0:
  - Go to DONE. done=1 for one cycle, outsig never rises, pulses_sent=0.
- HIGH:
  - outsig=1 for exactly HIGH_CYCLES cycles.
  - On the last HIGH cycle, pulses_sent increments by 1.
  - If the new value == target, go to DONE. Otherwise load GAP_CYCLES and go to GAP.
- GAP:
  - outsig=0 for exactly GAP_CYCLES cycles, then load HIGH_CYCLES and go to HIGH.
- DONE:
  - One cycle with done=1, busy=0, outsig=0; then IDLE.
  - start asserted in DONE is ignored; the source must re-assert it in IDLE.
- start and count changes while busy or in DONE are ignored. The latched target governs the burst.
- pulses_sent holds its final value after DONE until the next accepted start or reset.
- Burst length from the accepting edge to the done cycle = count*HIGH_CYCLES + (count-1)*GAP_CYCLES + 1 cycles.
- Max count 2^CNT_W-1:
  - pulses_sent reaches target exactly and never wraps.
  - Compare at the full CNT_W width, no overflow bit needed.
- start held high continuously produces back-to-back bursts, each separated by the DONE cycle plus one IDLE cycle.

Decomposition:
- Shared package pulse_pkg:
  - state encoding constants S_IDLE=2'b00, S_HIGH=2'b01, S_GAP=2'b10, S_DONE=2'b11.
  - default CNT_W.
  - The detector reuses the same encoding constants.
- One natural sub-module: phase_counter.
  - Loadable down-counter with load value, load enable and terminal-count flag.
  - Shares the async active-low reset and times both HIGH and GAP phases.

Test Plan:
- Reset, then start=1 with count=3 for one cycle (HIGH=1, GAP=2, accepted at edge 0):
  - outsig high in cycles 1, 4 and 7 only; busy high in cycles 1-7.
  - done=1 in cycle 8 only; pulses_sent=3 afterwards.
- start with count=0: no outsig edge, done=1 the next cycle, busy never asserts, pulses_sent=0.
- count=15 (max): exactly 15 rising edges on outsig; pulses_sent=15, with no wrap to 0 before done.
- Change count from 3 to 7 and pulse start again during the burst: still exactly 3 pulses, and no second burst starts.
- Drop reset to 0 asynchronously mid-HIGH of pulse 2:
  - outsig, busy and pulses_sent are 0 immediately, before the next clk edge.
  - After release, state is IDLE and no pulses appear without a new start.
- Hold start=1 continuously with count=2: repeated bursts of 2 pulses, done strobes 1 cycle wide, one IDLE cycle between DONE and the next burst's HIGH.
- Loop-back with the detector: the detector alert output matches pulses_sent after done.
